// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
//   Round-robin arbiter driving the Sel input of an 8:1 data mux. One of
//   eight requesting channels is granted and held on Sel until the
//   downstream consumer takes the word (out_valid & out_ready). Completed
//   transfers are counted in a wrapping counter.
//
// Ports
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset
//   req[7:0]   : per-channel request
//   out_ready  : downstream accepts the muxed word
//   Sel[2:0]   : granted channel index (to mux Sel)
//   grant[7:0] : one-hot grant while out_valid, zero otherwise
//   out_valid  : muxed word is valid
//   xfer_cnt   : completed handshakes, modulo 2^CNT_W
module mux_sel_arbiter #(
  parameter int         CNT_W     = 16,
  parameter logic [2:0] START_PTR = 3'd7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       req,
  input  logic             out_ready,
  output logic [2:0]       Sel,
  output logic [7:0]       grant,
  output logic             out_valid,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       last_q, last_d;
  logic [7:0]       grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Search last+1 .. last+7, then last itself; first set bit wins.
  // When k reaches 8 the 3-bit index wraps back onto last, so a lone
  // requester can be granted again.
  function automatic logic [2:0] rr_pick(input logic [7:0] r,
                                         input logic [2:0] last);
    logic [2:0] idx;
    logic [2:0] p;
    logic       found;
    p     = last;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last + 3'(k);
      if (!found && r[idx]) begin
        p     = idx;
        found = 1'b1;
      end
    end
    return p;
  endfunction

  logic [2:0] pick_idle, pick_next;
  assign pick_idle = rr_pick(req, last_q);
  assign pick_next = rr_pick(req, sel_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req != 8'h00) begin
          sel_d   = pick_idle;
          last_d  = pick_idle;
          grant_d = 8'b1 << pick_idle;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Without a handshake everything holds; no re-arbitration.
        if (out_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (req != 8'h00) begin
            // Back-to-back: the just-served channel is searched last.
            sel_d   = pick_next;
            last_d  = pick_next;
            grant_d = 8'b1 << pick_next;
          end else begin
            grant_d = 8'h00;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      last_q  <= START_PTR;
      grant_q <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Sel       = sel_q;
  assign grant     = grant_q;
  assign out_valid = (state_q == GRANT);
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
module tb_mux_sel_arbiter;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       req;
  logic             out_ready;
  logic [2:0]       Sel;
  logic [7:0]       grant;
  logic             out_valid;
  logic [CNT_W-1:0] xfer_cnt;

  int checks = 0;
  int errors = 0;

  mux_sel_arbiter #(.CNT_W(CNT_W), .START_PTR(3'd7)) dut (
    .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
    .Sel(Sel), .grant(grant), .out_valid(out_valid), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: what the outputs must be, derived from the arbitration
  // rules. Counter is modelled as an integer reduced modulo 2^CNT_W.
  logic       m_vld;
  int         m_sel;
  int         m_last;
  int         m_cnt;

  function automatic int m_pick(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++)
      if (r[(last + k) % 8]) return (last + k) % 8;
    return last;
  endfunction

  function automatic logic [7:0] m_grant();
    return m_vld ? (8'h01 << m_sel) : 8'h00;
  endfunction

  // Advance one clock; model consumes the inputs present at the edge.
  task automatic step();
    logic [7:0] r;
    logic       rd, rs;
    r = req; rd = out_ready; rs = rst;
    @(posedge clk);
    #1;
    if (rs) begin
      m_vld = 1'b0; m_sel = 0; m_last = 7; m_cnt = 0;
    end else if (!m_vld) begin
      if (r != 8'h00) begin
        m_sel = m_pick(r, m_last); m_last = m_sel; m_vld = 1'b1;
      end
    end else if (rd) begin
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (r != 8'h00) begin
        m_sel = m_pick(r, m_sel); m_last = m_sel;
      end else begin
        m_vld = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (Sel !== 3'd0 || grant !== 8'h00 || out_valid !== 1'b0 || xfer_cnt !== 4'd0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got Sel=%0d grant=%h vld=%b cnt=%0d want 0/00/0/0",
                 i, Sel, grant, out_valid, xfer_cnt);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h10; out_ready = 1'b1;
    step();
    checks++;
    if (Sel !== 3'd4 || grant !== 8'h10 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_grant got Sel=%0d grant=%h vld=%b want 4/10/1", Sel, grant, out_valid);
    end
    req = 8'h00;
    step();
    checks++;
    if (out_valid !== 1'b0 || xfer_cnt !== 4'd1 || grant !== 8'h00) begin
      errors++;
      $display("FAIL single_done got vld=%b cnt=%0d grant=%h want 0/1/00", out_valid, xfer_cnt, grant);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (Sel !== 3'(i % 8) || out_valid !== 1'b1 || grant !== (8'h01 << (i % 8))) begin
        errors++;
        $display("FAIL rr_seq step %0d got Sel=%0d vld=%b grant=%h want Sel=%0d", i, Sel, out_valid, grant, i % 8);
      end
    end
    step();
    checks++;
    if (xfer_cnt !== 4'd9) begin
      errors++;
      $display("FAIL rr_count got %0d want 9", xfer_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 8'h05; out_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (Sel !== 3'd0 || grant !== 8'h01 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got Sel=%0d grant=%h vld=%b want 0/01/1", i, Sel, grant, out_valid);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (Sel !== 3'd2 || grant !== 8'h04 || xfer_cnt !== 4'd1) begin
      errors++;
      $display("FAIL bp_next got Sel=%0d grant=%h cnt=%0d want 2/04/1", Sel, grant, xfer_cnt);
    end
  endtask

  task automatic test_lone_b2b();
    int prev;
    bit wrapped;
    do_reset();
    req = 8'h80; out_ready = 1'b1;
    step();
    prev = int'(xfer_cnt);
    wrapped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (Sel !== 3'd7 || out_valid !== 1'b1 || int'(xfer_cnt) != (prev + 1) % 16) begin
        errors++;
        $display("FAIL lone_b2b cyc %0d got Sel=%0d vld=%b cnt=%0d want 7/1/%0d",
                 i, Sel, out_valid, xfer_cnt, (prev + 1) % 16);
      end
      if (prev == 15 && xfer_cnt == 4'd0) wrapped = 1'b1;
      prev = int'(xfer_cnt);
    end
    checks++;
    if (!wrapped) begin
      errors++;
      $display("FAIL lone_wrap got no 15->0 transition want wrap");
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 8'h08; out_ready = 1'b0;
    step();
    checks++;
    if (Sel !== 3'd3 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup got Sel=%0d vld=%b want 3/1", Sel, out_valid);
    end
    rst = 1'b1; out_ready = 1'b1;
    step();
    checks++;
    if (xfer_cnt !== 4'd0 || out_valid !== 1'b0 || grant !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got cnt=%0d vld=%b grant=%h want 0/0/00", xfer_cnt, out_valid, grant);
    end
    rst = 1'b0; out_ready = 1'b0; req = 8'h08;
    step();
    checks++;
    if (Sel !== 3'd3 || out_valid !== 1'b1 || grant !== 8'h08) begin
      errors++;
      $display("FAIL mid_regrant got Sel=%0d vld=%b grant=%h want 3/1/08", Sel, out_valid, grant);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 99) < 2);
      out_ready = ($urandom_range(0, 99) < 60);
      case ($urandom_range(0, 3))
        0:       req = 8'h00;
        1:       req = 8'h01 << $urandom_range(0, 7);
        default: req = 8'($urandom);
      endcase
      step();
      checks++;
      if (out_valid !== m_vld || grant !== m_grant() || int'(xfer_cnt) != m_cnt ||
          (m_vld && int'(Sel) != m_sel)) begin
        errors++;
        $display("FAIL random cyc %0d got Sel=%0d grant=%h vld=%b cnt=%0d want Sel=%0d grant=%h vld=%b cnt=%0d",
                 i, Sel, grant, out_valid, xfer_cnt, m_sel, m_grant(), m_vld, m_cnt);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_vld = 1'b0; m_sel = 0; m_last = 7; m_cnt = 0;
    rst = 1'b1; req = 8'h00; out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_lone_b2b();
    test_reset_mid_grant();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 8:1 16-bit data mux and drives its 3-bit `Sel` input.
- Eight channels raise request lines. The block picks one, presents its index on `Sel`, and holds it stable until the downstream consumer accepts the muxed word through a valid/ready handshake.
- It also keeps a running count of completed transfers for debug and status.

Parameters:
- `CNT_W`, 16: width of the transfer counter `xfer_cnt`.
- `START_PTR`, 7: reset value of the last-granted pointer. With 7, channel 0 has first priority after reset.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 8: per-channel request; bit k means channel k has a word on mux input k.
- `out_ready` input 1: downstream accepts the muxed word this cycle.
- `Sel` output 3: index of the granted channel; connects to the mux `Sel`.
- `grant` output 8: one-hot grant, bit `Sel` set while `out_valid`=1; all zeros otherwise.
- `out_valid` output 1: the mux output selected by `Sel` is valid.
- `xfer_cnt` output `CNT_W`: number of completed handshakes, wraps modulo 2^`CNT_W`.

Behaviour:
- All outputs and state are registered; there is no combinational path from `req`/`out_ready` to any output.
- Reset (synchronous, `rst`=1 at a rising edge):
  - `Sel`=0, `grant`=0, `out_valid`=0, `xfer_cnt`=0.
  - Internal `last_ptr`=`START_PTR`; state = IDLE.
  - Reset overrides everything in the same cycle, including a handshake in progress. That transfer is not counted, and `out_valid` drops the next cycle.
- Round-robin pick function, given `req` and `last_ptr`:
  - Search channels `last_ptr`+1, +2, … wrapping modulo 8, ending with `last_ptr` itself.
  - The first set bit wins.
  - `last_ptr` is included last, so a lone requester can be re-granted.
- State IDLE (`out_valid`=0):
  - If `req`≠0: load `Sel`=pick, `grant`=1<<pick, `out_valid`=1, `last_ptr`=pick, go to GRANT.
  - Latency: `req` sampled at edge N gives `out_valid` high after edge N (one cycle).
  - If `req`=0: stay in IDLE; outputs unchanged (`Sel` holds its last value, `grant`=0).
- State GRANT (`out_valid`=1):
  - Handshake = `out_valid` & `out_ready`.
  - Without a handshake: `Sel`, `grant` and `out_valid` are held exactly; no re-arbitration.
  - Dropping `req[Sel]` while granted is a protocol violation. The grant is held anyway, and the block takes no recovery action.
  - With a handshake: `xfer_cnt` += 1.
    - If `req` (sampled the same cycle) ≠ 0: re-pick using the updated `last_ptr`=current `Sel`, load the new `Sel`/`grant`, keep `out_valid`=1 and stay in GRANT. This gives back-to-back transfers with no bubble.
    - If `req`=0: `out_valid`=0, `grant`=0, go to IDLE.
- A requester must keep `req` high through the handshake cycle. It deasserts `req` on the cycle after the handshake if it has no further data.
  - The `req` value sampled in the handshake cycle still includes the just-served channel. Because the served channel is searched last, fairness is preserved.
- Counter: `xfer_cnt` wraps from 2^`CNT_W`-1 to 0 without any flag.
- Invariants:
  - `grant` is one-hot exactly when `out_valid`=1 and zero otherwise.
  - `Sel` never changes while `out_valid`=1 and `out_ready`=0.
- Implementation: two-state FSM plus an 8-way rotate-priority encoder; no latches; every case has a default.

Test Plan:
- Reset then idle:
  - Stimulus: `rst`=1 for 2 cycles, then `req`=0.
  - Required: `Sel`=0, `grant`=0, `out_valid`=0, `xfer_cnt`=0 held for 10 cycles.
- Single request:
  - Stimulus: `req`=8'h10 at edge N, `out_ready`=1.
  - Required: at N+1, `Sel`=4, `grant`=8'h10, `out_valid`=1. After the handshake with `req` dropped: `out_valid`=0 and `xfer_cnt`=1.
- Full round-robin:
  - Stimulus: `req`=8'hFF held, `out_ready`=1 constant.
  - Required: `Sel` sequence 0,1,2,…,7,0 on consecutive cycles; `out_valid` never drops; `xfer_cnt`=9 after 9 grants.
- Backpressure:
  - Stimulus: `req`=8'h05, `out_ready`=0 for 5 cycles, then 1.
  - Required: `Sel`=0 and `grant`=8'h01 stable for all 5 cycles. After acceptance, `Sel`=2 the next cycle.
- Lone back-to-back requester:
  - Stimulus: `req`=8'h80 held, `out_ready`=1.
  - Required: `Sel`=7 and `out_valid`=1 continuously; `xfer_cnt` increments every cycle. With `CNT_W`=4, the counter wraps 15→0.
- Reset mid-grant:
  - Stimulus: in GRANT with `Sel`=3, assert `rst` in the same cycle as `out_ready`=1.
  - Required: `xfer_cnt` stays 0, `out_valid`=0 next cycle. After release with `req`=8'h08, the next `Sel`=3, since the `START_PTR` search from 0 finds channel 3.
